mem_read_arbiter: RTL
=====================

Name: mem_read_arbiter

Overview:
- Shares one AXI4 read channel (AR + R) of the memory interface between NUM_PORTS read requesters (e.g. texture and framebuffer read request generators).
- AR requests are arbitrated round-robin. The winning port index is prepended to the request ID.
- Read data is routed back to the owning port by decoding those ID bits.
- Per-port outstanding-burst counters stop any single requester from flooding the shared memory queue.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8)
- DATA_WIDTH, 32, AXI data width in bits
- ADDR_WIDTH, 32, AXI address width in bits
- ID_WIDTH, 8, requester-side ID width
- MAX_OUTSTANDING, 4, maximum in-flight bursts per port (1..255)
- PORT_LG, max(1, clog2(NUM_PORTS)) (localparam), number of port-index bits added to the ID

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_axi_arvalid  in  NUM_PORTS  per-port AR valid
- s_axi_arready  out  NUM_PORTS  per-port AR ready
- s_axi_arid  in  NUM_PORTS*ID_WIDTH  per-port ID; port i occupies slice [i*ID_WIDTH +: ID_WIDTH]
- s_axi_araddr  in  NUM_PORTS*ADDR_WIDTH  per-port address
- s_axi_arlen  in  NUM_PORTS*8  per-port burst length
- s_axi_arsize  in  NUM_PORTS*3  per-port beat size
- s_axi_arburst  in  NUM_PORTS*2  per-port burst type
- s_axi_rvalid  out  NUM_PORTS  per-port R valid
- s_axi_rready  in  NUM_PORTS  per-port R ready
- s_axi_rid  out  ID_WIDTH  broadcast: low ID_WIDTH bits of m_mem_axi_rid
- s_axi_rdata  out  DATA_WIDTH  broadcast read data
- s_axi_rresp  out  2  broadcast response
- s_axi_rlast  out  1  broadcast last-beat flag
- m_mem_axi_arid  out  ID_WIDTH+PORT_LG  {port index, requester ID}
- m_mem_axi_araddr  out  ADDR_WIDTH  address
- m_mem_axi_arlen  out  8  burst length
- m_mem_axi_arsize  out  3  beat size
- m_mem_axi_arburst  out  2  burst type
- m_mem_axi_arlock  out  1  constant 0
- m_mem_axi_arcache  out  4  constant 0
- m_mem_axi_arprot  out  3  constant 0
- m_mem_axi_arvalid  out  1  AR valid
- m_mem_axi_arready  in  1  AR ready
- m_mem_axi_rid  in  ID_WIDTH+PORT_LG  R ID
- m_mem_axi_rdata  in  DATA_WIDTH  read data
- m_mem_axi_rresp  in  2  response
- m_mem_axi_rlast  in  1  last beat
- m_mem_axi_rvalid  in  1  R valid
- m_mem_axi_rready  out  1  R ready

Behaviour:
- Reset (async, resetn=0), all registers cleared immediately:
  - m_mem_axi_arvalid=0, m_mem_axi_arid=0, m_mem_axi_araddr=0, m_mem_axi_arlen=0, m_mem_axi_arsize=0, m_mem_axi_arburst=0.
  - Round-robin pointer=NUM_PORTS-1, so port 0 has first priority.
  - All outstanding counters=0.
  - A reset mid-burst discards all in-flight bookkeeping; the memory side must be reset together with this block.
- Eligibility: port i is eligible when s_axi_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Grant (combinational): the first eligible port searching upward from pointer+1, wrapping modulo NUM_PORTS. At most one grant per cycle.
- AR slot free: m_mem_axi_arvalid=0 or m_mem_axi_arready=1.
- s_axi_arready[i] = slot free AND grant==i (combinational, one-hot or zero).
- On an s-side AR handshake for port i:
  - AR output registers load the port-i payload.
  - m_mem_axi_arid = {i[PORT_LG-1:0], arid_i}.
  - m_mem_axi_arvalid=1 on the next cycle.
  - pointer := i.
- AR pipeline: one register stage; latency 1 cycle from s handshake to m_mem_axi_arvalid. Throughput 1 request/cycle while arready=1.
- AR release: m_mem_axi_arready=1 with no new grant clears m_mem_axi_arvalid. The AR payload is held stable while arvalid=1 and arready=0.
- R routing (combinational, no buffering):
  - sel = m_mem_axi_rid[ID_WIDTH +: PORT_LG].
  - s_axi_rvalid[sel] = m_mem_axi_rvalid; all other bits 0.
  - m_mem_axi_rready = s_axi_rready[sel].
  - If sel >= NUM_PORTS: no s_axi_rvalid asserted, m_mem_axi_rready=1, beat dropped.
- Counters cnt[i], 8-bit:
  - +1 on an AR handshake of port i.
  - -1 on an R handshake of port i with rlast=1.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING, since a full port is ineligible. Never decremented below 0; a stray rlast at 0 is ignored.
- NUM_PORTS=1: PORT_LG=1, ID top bit always 0, grant is port 0 whenever eligible.

Test Plan:
- Single port 0 request (addr=0x1000, id=3, len=0) with arready held 1 -> s_axi_arready[0]=1 in the request cycle. Next cycle arvalid=1, araddr=0x1000, arid=0x003 (ID_WIDTH=8, PORT_LG=1).
- Ports 0 and 1 both hold arvalid continuously, arready=1 -> grants alternate 0,1,0,1. m_mem_axi_arid bit 8 toggles every cycle.
- arready held 0 for 5 cycles with arvalid=1 -> payload stable, no s_axi_arready asserted, no request lost. When arready rises, the next grant issues in that same cycle.
- MAX_OUTSTANDING=2, port 0 issues 3 requests with no R beats -> the third stalls (arready[0]=0). Port 1 is still granted. One R beat with rid=0x0xx and rlast=1 -> the port-0 stall releases the next cycle.
- R beat with rid=0x105, rlast=1, s_axi_rready[1]=0 -> s_axi_rvalid[1]=1, m_mem_axi_rready=0. Raising rready[1] completes the beat and decrements cnt[1].
- Assert resetn=0 asynchronously mid-traffic -> arvalid drops without waiting for a clock edge, counters=0. After release, port 0 is granted first.

Source files
------------

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: requester-side and memory-side AXI4 read channel bundle for the arbiter
interface mem_read_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    localparam int PORT_LG = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    logic [NUM_PORTS-1:0]            s_axi_arvalid;
    logic [NUM_PORTS-1:0]            s_axi_arready;
    logic [NUM_PORTS*ID_WIDTH-1:0]   s_axi_arid;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_araddr;
    logic [NUM_PORTS*8-1:0]          s_axi_arlen;
    logic [NUM_PORTS*3-1:0]          s_axi_arsize;
    logic [NUM_PORTS*2-1:0]          s_axi_arburst;
    logic [NUM_PORTS-1:0]            s_axi_rvalid;
    logic [NUM_PORTS-1:0]            s_axi_rready;
    logic [ID_WIDTH-1:0]             s_axi_rid;
    logic [DATA_WIDTH-1:0]           s_axi_rdata;
    logic [1:0]                      s_axi_rresp;
    logic                            s_axi_rlast;
    logic [ID_WIDTH+PORT_LG-1:0]     m_mem_axi_arid;
    logic [ADDR_WIDTH-1:0]           m_mem_axi_araddr;
    logic [7:0]                      m_mem_axi_arlen;
    logic [2:0]                      m_mem_axi_arsize;
    logic [1:0]                      m_mem_axi_arburst;
    logic                            m_mem_axi_arlock;
    logic [3:0]                      m_mem_axi_arcache;
    logic [2:0]                      m_mem_axi_arprot;
    logic                            m_mem_axi_arvalid;
    logic                            m_mem_axi_arready;
    logic [ID_WIDTH+PORT_LG-1:0]     m_mem_axi_rid;
    logic [DATA_WIDTH-1:0]           m_mem_axi_rdata;
    logic [1:0]                      m_mem_axi_rresp;
    logic                            m_mem_axi_rlast;
    logic                            m_mem_axi_rvalid;
    logic                            m_mem_axi_rready;
    modport slave (
        input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_rready,
        output s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        output m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize, m_mem_axi_arburst,
        output m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot, m_mem_axi_arvalid, m_mem_axi_rready,
        input  m_mem_axi_arready, m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp, m_mem_axi_rlast, m_mem_axi_rvalid
    );
    modport master (
        output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_rready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        input  m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize, m_mem_axi_arburst,
        input  m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot, m_mem_axi_arvalid, m_mem_axi_rready,
        output m_mem_axi_arready, m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp, m_mem_axi_rlast, m_mem_axi_rvalid
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one AXI4 read channel, port index carried in the upper ID bits
module mem_read_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic aclk,
    input logic resetn,
    mem_read_arbiter_if.slave bus
);
    localparam int PORT_LG = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    logic [PORT_LG-1:0]   ptr, gnt, sel;
    logic                 gnt_ok, take, sel_ok;
    logic [NUM_PORTS-1:0] elig, inc, dec;
    logic [7:0]           cnt [NUM_PORTS];
    always_comb begin
        gnt_ok = 1'b0;
        gnt = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!gnt_ok && elig[(int'(ptr) + k) % NUM_PORTS]) begin
                gnt_ok = 1'b1;
                gnt = PORT_LG'((int'(ptr) + k) % NUM_PORTS);
            end
        end
    end
    assign take = gnt_ok && (!bus.m_mem_axi_arvalid || bus.m_mem_axi_arready);
    assign bus.s_axi_arready = take ? NUM_PORTS'(1) << gnt : '0;
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            bus.m_mem_axi_arvalid <= 1'b0;
            bus.m_mem_axi_arid <= '0;
            bus.m_mem_axi_araddr <= '0;
            bus.m_mem_axi_arlen <= '0;
            bus.m_mem_axi_arsize <= '0;
            bus.m_mem_axi_arburst <= '0;
            ptr <= PORT_LG'(NUM_PORTS - 1);
        end else if (take) begin
            bus.m_mem_axi_arvalid <= 1'b1;
            bus.m_mem_axi_arid <= {gnt, bus.s_axi_arid[int'(gnt)*ID_WIDTH +: ID_WIDTH]};
            bus.m_mem_axi_araddr <= bus.s_axi_araddr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.m_mem_axi_arlen <= bus.s_axi_arlen[int'(gnt)*8 +: 8];
            bus.m_mem_axi_arsize <= bus.s_axi_arsize[int'(gnt)*3 +: 3];
            bus.m_mem_axi_arburst <= bus.s_axi_arburst[int'(gnt)*2 +: 2];
            ptr <= gnt;
        end else if (bus.m_mem_axi_arready) begin
            bus.m_mem_axi_arvalid <= 1'b0;
        end
    end
    assign bus.m_mem_axi_arlock = 1'b0;
    assign bus.m_mem_axi_arcache = '0;
    assign bus.m_mem_axi_arprot = '0;
    // Beats tagged with a nonexistent port are accepted and dropped so the memory never stalls on them
    assign sel = bus.m_mem_axi_rid[ID_WIDTH +: PORT_LG];
    assign sel_ok = int'(sel) < NUM_PORTS;
    assign bus.s_axi_rvalid = (sel_ok && bus.m_mem_axi_rvalid) ? NUM_PORTS'(1) << sel : '0;
    assign bus.m_mem_axi_rready = sel_ok ? bus.s_axi_rready[sel] : 1'b1;
    assign bus.s_axi_rid = bus.m_mem_axi_rid[ID_WIDTH-1:0];
    assign bus.s_axi_rdata = bus.m_mem_axi_rdata[DATA_WIDTH-1:0];
    assign bus.s_axi_rresp = bus.m_mem_axi_rresp;
    assign bus.s_axi_rlast = bus.m_mem_axi_rlast;
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign elig[i] = bus.s_axi_arvalid[i] && cnt[i] < 8'(MAX_OUTSTANDING);
        assign inc[i] = take && gnt == PORT_LG'(i);
        assign dec[i] = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready && bus.m_mem_axi_rlast && sel_ok && sel == PORT_LG'(i);
        always_ff @(posedge aclk or negedge resetn) begin
            if (!resetn) cnt[i] <= '0;
            else if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 8'd1;
            else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 8'd1;
        end
    end
endmodule
